// File: rtl/func_minterm_scanner.sv
// Exhaustive stimulus/capture stage for a sum-of-products function block.
// Walks every input vector in ascending order, samples F after FUNC_LATENCY
// advances, and streams the indices of true vectors on a valid/ready port.
module func_minterm_scanner #(
  parameter int unsigned N_INPUTS     = 10,
  parameter int unsigned FUNC_LATENCY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [N_INPUTS-1:0] x_out,
  output logic                fn_en,
  input  logic                f_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [N_INPUTS-1:0] m_index,
  output logic                busy,
  output logic                done,
  output logic [N_INPUTS:0]   count
);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  localparam logic [N_INPUTS-1:0] IdxOne = {{(N_INPUTS-1){1'b0}}, 1'b1};
  localparam logic [N_INPUTS:0]   CntOne = {{N_INPUTS{1'b0}}, 1'b1};
  localparam logic [N_INPUTS-1:0] IdxMax = {N_INPUTS{1'b1}};

  state_e              state_q, state_d;
  logic [N_INPUTS-1:0] idx_q;
  logic [N_INPUTS:0]   count_q;
  logic                m_valid_q;
  logic [N_INPUTS-1:0] m_index_q;

  logic                advance;
  logic                scanning;
  logic                clear_scan;
  logic                last_idx;
  logic                tags_clear;
  logic                emerge_tag;
  logic [N_INPUTS-1:0] emerge_idx;
  logic                capture;

  // A beat held by the sink freezes the whole pipeline, function included.
  assign advance  = !(m_valid_q && !m_ready);
  assign scanning = (state_q == StScan);
  assign last_idx = (idx_q == IdxMax);
  assign capture  = advance && emerge_tag && f_in;

  assign x_out   = idx_q;
  assign fn_en   = advance;
  assign m_valid = m_valid_q;
  assign m_index = m_index_q;
  assign count   = count_q;

  // Delay line pairing each issued index with the F that returns for it.
  if (FUNC_LATENCY == 0) begin : g_comb
    assign emerge_idx = idx_q;
    assign emerge_tag = scanning;
    assign tags_clear = 1'b1;
  end else begin : g_pipe
    logic [N_INPUTS-1:0]     dl_idx_q [FUNC_LATENCY];
    logic [FUNC_LATENCY-1:0] dl_tag_q;

    // Shift {index, tag} one stage per advance; tag marks a real issue.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned k = 0; k < FUNC_LATENCY; k++) begin
          dl_idx_q[k] <= '0;
          dl_tag_q[k] <= 1'b0;
        end
      end else if (advance) begin
        dl_idx_q[0] <= idx_q;
        dl_tag_q[0] <= scanning;
        for (int unsigned k = 1; k < FUNC_LATENCY; k++) begin
          dl_idx_q[k] <= dl_idx_q[k-1];
          dl_tag_q[k] <= dl_tag_q[k-1];
        end
      end
    end

    assign emerge_idx = dl_idx_q[FUNC_LATENCY-1];
    assign emerge_tag = dl_tag_q[FUNC_LATENCY-1];
    assign tags_clear = ~|dl_tag_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_d    = state_q;
    clear_scan = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StScan;
          clear_scan = 1'b1;
        end
      end
      StScan: begin
        busy = 1'b1;
        if (advance && last_idx) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        busy = 1'b1;
        // advance here also means no beat is left pending.
        if (advance && tags_clear) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Index counter: holds at the last vector rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear_scan) begin
      idx_q <= '0;
    end else if (scanning && advance && !last_idx) begin
      idx_q <= idx_q + IdxOne;
    end
  end

  // Live minterm count.
  always_ff @(posedge clk) begin
    if (rst || clear_scan) begin
      count_q <= '0;
    end else if (capture) begin
      count_q <= count_q + CntOne;
    end
  end

  // Output beat register; reloads or empties on every advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_index_q <= '0;
    end else if (advance) begin
      m_valid_q <= capture;
      if (capture) begin
        m_index_q <= emerge_idx;
      end
    end
  end

endmodule
